// File: rtl/bit_serializer.sv
// Parallel-to-serial transmitter with a one-word holding register so that
// back-to-back words stream out one bit per clock with no idle cycle between them.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             d_out,
    output logic             d_valid,
    output logic             last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             hold_full_q, hold_full_d;

    logic             transfer;
    logic             final_bit;
    logic [WIDTH-1:0] shifted;

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            hold_q      <= '0;
            cnt_q       <= '0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            cnt_q       <= cnt_d;
            hold_full_q <= hold_full_d;
        end
    end

    // The bit on the wire is always at the shift register's outgoing end,
    // so each shift moves the next bit into that position.
    always_comb begin
        transfer  = load_valid && !hold_full_q;
        final_bit = (state_q == SHIFT) && (cnt_q == LAST_CNT);
        if (MSB_FIRST) begin
            shifted = {shift_q[WIDTH-2:0], 1'b0};
        end else begin
            shifted = {1'b0, shift_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        cnt_d       = cnt_q;
        hold_full_d = hold_full_q;

        case (state_q)
            IDLE: begin
                if (transfer) begin
                    shift_d = load_data;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // On the final bit a held word wins; load_ready is low then anyway.
                if (final_bit) begin
                    cnt_d = '0;
                    if (hold_full_q) begin
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                    end else if (transfer) begin
                        shift_d = load_data;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    shift_d = shifted;
                    cnt_d   = cnt_q + 1'b1;
                    if (transfer) begin
                        hold_d      = load_data;
                        hold_full_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        load_ready = !hold_full_q;
        d_valid    = (state_q == SHIFT);
        last       = final_bit;
        busy       = (state_q == SHIFT) || hold_full_q;
        d_out      = 1'b0;
        if (state_q == SHIFT) begin
            d_out = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench: an MSB-first and an LSB-first serializer share one stimulus
// stream and are compared every cycle against a word-queue reference model.
module tb_bit_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         clr = 1'b1;
    logic         loadValid = 1'b0;
    logic [W-1:0] loadData = '0;

    logic readyM, doutM, validM, lastM, busyM;
    logic readyL, doutL, validL, lastL, busyL;

    int passCnt = 0;
    int checkCnt = 0;
    bit checkEn = 1'b0;

    // Reference model: the word currently on the wire, its bit index, and the
    // words accepted but not yet started.
    bit           mActive = 1'b0;
    int           mPos = 0;
    logic [W-1:0] mCur = '0;
    logic [W-1:0] mPend[$];
    bit           mAccepted = 1'b0;
    bit           mXfer;
    bit           mUsed;

    logic [31:0] capDutM, capDutL, capModM, capModL;
    int          runLen, maxRun, validCnt, lastCnt, readyLowCnt;

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dutMsb (
        .clk(clk), .clr(clr), .load_valid(loadValid), .load_ready(readyM),
        .load_data(loadData), .d_out(doutM), .d_valid(validM), .last(lastM), .busy(busyM)
    );

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dutLsb (
        .clk(clk), .clr(clr), .load_valid(loadValid), .load_ready(readyL),
        .load_data(loadData), .d_out(doutL), .d_valid(validL), .last(lastL), .busy(busyL)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checkCnt++;
        if (got !== exp) begin
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end else begin
            passCnt++;
        end
    endtask

    function automatic logic expBit(input bit msb);
        if (!mActive) return 1'b0;
        return msb ? mCur[W-1-mPos] : mCur[mPos];
    endfunction

    always @(posedge clk) begin
        mAccepted = 1'b0;
        if (clr) begin
            mActive = 1'b0;
            mPos = 0;
            mPend.delete();
        end else begin
            mXfer = loadValid && (mPend.size() == 0);
            mUsed = 1'b0;
            if (mActive) begin
                if (mPos == W - 1) begin
                    if (mPend.size() > 0) begin
                        mCur = mPend.pop_front();
                        mPos = 0;
                    end else if (mXfer) begin
                        mCur = loadData;
                        mPos = 0;
                        mUsed = 1'b1;
                    end else begin
                        mActive = 1'b0;
                    end
                end else begin
                    mPos++;
                end
            end else if (mXfer) begin
                mCur = loadData;
                mPos = 0;
                mActive = 1'b1;
                mUsed = 1'b1;
            end
            if (mXfer && !mUsed) mPend.push_back(loadData);
            mAccepted = mXfer;
        end
    end

    // Per-cycle comparison plus stream capture, both away from the active edge.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("dOutMsb",   {31'b0, doutM},  {31'b0, expBit(1'b1)});
            checkOutput("dValidMsb", {31'b0, validM}, {31'b0, mActive});
            checkOutput("lastMsb",   {31'b0, lastM},  {31'b0, mActive && (mPos == W - 1)});
            checkOutput("busyMsb",   {31'b0, busyM},  {31'b0, mActive || (mPend.size() > 0)});
            checkOutput("readyMsb",  {31'b0, readyM}, {31'b0, mPend.size() == 0});
            checkOutput("dOutLsb",   {31'b0, doutL},  {31'b0, expBit(1'b0)});
            checkOutput("dValidLsb", {31'b0, validL}, {31'b0, mActive});
            checkOutput("lastLsb",   {31'b0, lastL},  {31'b0, mActive && (mPos == W - 1)});
            checkOutput("busyLsb",   {31'b0, busyL},  {31'b0, mActive || (mPend.size() > 0)});
            checkOutput("readyLsb",  {31'b0, readyL}, {31'b0, mPend.size() == 0});
        end
        if (validM === 1'b1) capDutM = {capDutM[30:0], doutM};
        if (validL === 1'b1) capDutL = {capDutL[30:0], doutL};
        if (mActive) begin
            capModM = {capModM[30:0], expBit(1'b1)};
            capModL = {capModL[30:0], expBit(1'b0)};
        end
        runLen = (validM === 1'b1) ? runLen + 1 : 0;
        if (runLen > maxRun) maxRun = runLen;
        if (validM === 1'b1) validCnt++;
        if (lastM === 1'b1) lastCnt++;
        if (readyM !== 1'b1) readyLowCnt++;
    end

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clearCapture();
        capDutM = '0; capDutL = '0; capModM = '0; capModL = '0;
        runLen = 0; maxRun = 0; validCnt = 0; lastCnt = 0; readyLowCnt = 0;
    endtask

    // Presents one word and holds it until the model reports the transfer edge.
    task automatic applyStimulus(input logic [W-1:0] word, input bit dropAfter);
        int waited;
        loadValid = 1'b1;
        loadData = word;
        waited = 0;
        do begin
            @(posedge clk);
            #1;
            waited++;
        end while (!mAccepted && waited < 40);
        if (!mAccepted) checkOutput("acceptTimeout", 32'd0, 32'd1);
        if (dropAfter) loadValid = 1'b0;
    endtask

    initial begin
        clearCapture();

        // Reset then idle
        clr = 1'b1;
        idleCycles(2);
        checkEn = 1'b1;
        checkOutput("rstValid", {31'b0, validM}, 32'd0);
        checkOutput("rstDout",  {31'b0, doutM},  32'd0);
        checkOutput("rstLast",  {31'b0, lastM},  32'd0);
        checkOutput("rstBusy",  {31'b0, busyM},  32'd0);
        checkOutput("rstReady", {31'b0, readyM}, 32'd1);
        clr = 1'b0;
        idleCycles(2);

        // Single word, both bit orders
        clearCapture();
        applyStimulus(8'hA5, 1'b1);
        idleCycles(12);
        checkOutput("a5DutMsb", capDutM & 32'hFF, 32'hA5);
        checkOutput("a5ModMsb", capModM & 32'hFF, 32'hA5);
        checkOutput("a5DutLsb", capDutL & 32'hFF, 32'hA5);
        checkOutput("a5Valid",  validCnt, 32'd8);
        checkOutput("a5Run",    maxRun,   32'd8);
        checkOutput("a5Last",   lastCnt,  32'd1);

        clearCapture();
        applyStimulus(8'h01, 1'b1);
        idleCycles(12);
        checkOutput("x01DutMsb", capDutM & 32'hFF, 32'h01);
        checkOutput("x01DutLsb", capDutL & 32'hFF, 32'h80);
        checkOutput("x01ModLsb", capModL & 32'hFF, 32'h80);

        // Back-to-back with holding-register stall
        clearCapture();
        applyStimulus(8'hF0, 1'b0);
        applyStimulus(8'h0F, 1'b0);
        applyStimulus(8'hFF, 1'b1);
        idleCycles(30);
        checkOutput("b2bDutMsb",  capDutM & 32'hFFFFFF, 32'hF00FFF);
        checkOutput("b2bModMsb",  capModM & 32'hFFFFFF, 32'hF00FFF);
        checkOutput("b2bValid",   validCnt,    32'd24);
        checkOutput("b2bRun",     maxRun,      32'd24);
        checkOutput("b2bLast",    lastCnt,     32'd3);
        checkOutput("b2bReadyLo", readyLowCnt, 32'd14);

        // Direct load on the final-bit edge
        clearCapture();
        applyStimulus(8'hC3, 1'b1);
        idleCycles(7);
        applyStimulus(8'h3C, 1'b1);
        idleCycles(12);
        checkOutput("directDutMsb", capDutM & 32'hFFFF, 32'hC33C);
        checkOutput("directRun",    maxRun,      32'd16);
        checkOutput("directLast",   lastCnt,     32'd2);
        checkOutput("directReadyLo", readyLowCnt, 32'd0);

        // Reset while shifting with a word held
        clearCapture();
        applyStimulus(8'hAA, 1'b1);
        applyStimulus(8'h55, 1'b1);
        idleCycles(2);
        clr = 1'b1;
        idleCycles(1);
        clr = 1'b0;
        checkOutput("midRstValid", {31'b0, validM}, 32'd0);
        checkOutput("midRstReady", {31'b0, readyM}, 32'd1);
        checkOutput("midRstBusy",  {31'b0, busyM},  32'd0);
        idleCycles(20);
        checkOutput("midRstBits",  validCnt, 32'd4);
        checkOutput("midRstData",  capDutM & 32'hF, 32'hA);
        checkOutput("midRstLast",  lastCnt,  32'd0);

        // Randomized traffic with occasional resets; the source holds until accepted
        loadValid = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            clr = ($urandom_range(0, 299) == 0);
            if (!loadValid || mAccepted || clr) begin
                loadValid = ($urandom_range(0, 99) < 60);
                loadData = W'($urandom);
            end
            @(posedge clk);
            #1;
        end
        clr = 1'b0;
        loadValid = 1'b0;
        idleCycles(25);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
